keypad_entry: RTL

- Upstream stage of the countdown clock: scans the 4x3 keypad matrix, debounces presses, and decodes them into a two-digit BCD minute setting.
- Issues a one-cycle load strobe that feeds the clock block's load / load_minute inputs.
- Runs on the 4 MHz system clock, replacing the ad-hoc keypad logic in the top level.

---
 rtl/keypad_pkg.sv | 42 ++++
 rtl/keypad_entry_if.sv | 28 ++
 rtl/keypad_scan.sv | 204 ++++++++++++++++++++
 rtl/keypad_entry.sv | 66 ++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared encodings for the keypad entry block: key codes, debounce states,
// per-frame scan classification and the matrix-position-to-key lookup.
package keypad_pkg;

  localparam logic [3:0] KEY_STAR = 4'd10;
  localparam logic [3:0] KEY_HASH = 4'd11;
  localparam logic [3:0] KEY_NONE = 4'd15;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PRESS_DB = 2'd1,
    HELD     = 2'd2,
    REL_DB   = 2'd3
  } db_state_e;

  typedef enum logic [1:0] {
    FRAME_NONE  = 2'd0,
    FRAME_KEY   = 2'd1,
    FRAME_MULTI = 2'd2
  } frame_res_e;

  // Matrix layout: rows 0..2 hold 1-9 left to right, row 3 holds * 0 #.
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    if (row == 2'd3) begin
      case (col)
        2'd0:    code = KEY_STAR;
        2'd1:    code = 4'd0;
        default: code = KEY_HASH;
      endcase
    end else begin
      code = ({2'b00, row} * 4'd3) + {2'b00, col} + 4'd1;
    end
    return code;
  endfunction

  // Number of active columns seen on one row sample.
  function automatic logic [1:0] popcount3(input logic [2:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]} + {1'b0, v[2]};
  endfunction

endpackage

// File: rtl/keypad_entry_if.sv
// Keypad matrix pins plus the decoded key / minute-load outputs.
// master: the keypad entry block; slave: the matrix and the clock block it feeds.
interface keypad_entry_if;
  logic [2:0] keypadc;
  logic [3:0] keypadr;
  logic       key_valid;
  logic [3:0] key_code;
  logic [7:0] minute;
  logic       load;

  modport master (
    input  keypadc,
    output keypadr,
    output key_valid,
    output key_code,
    output minute,
    output load
  );

  modport slave (
    output keypadc,
    input  keypadr,
    input  key_valid,
    input  key_code,
    input  minute,
    input  load
  );
endinterface

// File: rtl/keypad_scan.sv
// Row scanner, column synchronizer, frame classifier and press/release
// debouncer for a 4x3 keypad matrix.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// IDLE     | no key held; waiting for a frame with exactly one key
// PRESS_DB | candidate key seen on cnt consecutive frames, not yet accepted
// HELD     | key accepted (key_valid issued); waiting for an empty frame
// REL_DB   | empty frames counting toward release; any hit returns to HELD
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4000,
  parameter int DEBOUNCE = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] keypadc,
  output logic [3:0] keypadr,
  output logic       key_valid,
  output logic [3:0] key_code
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE + 1);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] DB_LAST    = CW'(DEBOUNCE);

  logic [2:0]    colm_q, colm_d;
  logic [2:0]    cols_q, cols_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    row_q, row_d;
  logic [1:0]    hits_q, hits_d;
  logic [3:0]    acc_key_q, acc_key_d;
  db_state_e     state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_valid_q, key_valid_d;
  logic [3:0]    key_code_q, key_code_d;

  logic          sample;
  logic          frame_done;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [1:0]    row_pop;
  logic [2:0]    hits_sum;
  logic [1:0]    hits_new;
  logic [3:0]    key_new;
  frame_res_e    frame_res;
  logic [CW-1:0] cnt_inc;

  // Register stage: synchronizer, scan counters, frame accumulator, debouncer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      colm_q      <= '0;
      cols_q      <= '0;
      dwell_q     <= '0;
      row_q       <= 4'b0001;
      hits_q      <= '0;
      acc_key_q   <= KEY_NONE;
      state_q     <= IDLE;
      cand_q      <= KEY_NONE;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_code_q  <= KEY_NONE;
    end else begin
      colm_q      <= colm_d;
      cols_q      <= cols_d;
      dwell_q     <= dwell_d;
      row_q       <= row_d;
      hits_q      <= hits_d;
      acc_key_q   <= acc_key_d;
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_code_q  <= key_code_d;
    end
  end

  // Decode the driven row and the single active column of this sample.
  always_comb begin
    row_idx = 2'd0;
    case (row_q)
      4'b0010: row_idx = 2'd1;
      4'b0100: row_idx = 2'd2;
      4'b1000: row_idx = 2'd3;
      default: row_idx = 2'd0;
    endcase
    col_idx = 2'd0;
    case (cols_q)
      3'b010:  col_idx = 2'd1;
      3'b100:  col_idx = 2'd2;
      default: col_idx = 2'd0;
    endcase
  end

  // Row dwell, rotation and frame accumulation; the frame ends on the row-3 sample.
  always_comb begin
    colm_d     = keypadc;
    cols_d     = colm_q;
    sample     = (dwell_q == DWELL_LAST);
    frame_done = sample && row_q[3];
    dwell_d    = sample ? '0 : dwell_q + 1'b1;
    row_d      = sample ? {row_q[2:0], row_q[3]} : row_q;

    row_pop  = popcount3(cols_q);
    hits_sum = {1'b0, hits_q} + {1'b0, row_pop};
    hits_new = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    key_new  = (hits_q == 2'd0 && row_pop == 2'd1) ? key_lookup(row_idx, col_idx) : acc_key_q;

    case (hits_new)
      2'd0:    frame_res = FRAME_NONE;
      2'd1:    frame_res = FRAME_KEY;
      default: frame_res = FRAME_MULTI;
    endcase

    hits_d    = hits_q;
    acc_key_d = acc_key_q;
    if (frame_done) begin
      hits_d    = '0;
      acc_key_d = KEY_NONE;
    end else if (sample) begin
      hits_d    = hits_new;
      acc_key_d = key_new;
    end
  end

  assign cnt_inc = cnt_q + CW'(1);

  // Debounce FSM: advances once per completed frame.
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_code_d  = key_code_q;
    if (frame_done) begin
      unique case (state_q)
        IDLE: begin
          if (frame_res == FRAME_KEY) begin
            cand_d = key_new;
            cnt_d  = CW'(1);
            if (DEBOUNCE <= 1) begin
              state_d     = HELD;
              cnt_d       = '0;
              key_valid_d = 1'b1;
              key_code_d  = key_new;
            end else begin
              state_d = PRESS_DB;
            end
          end
        end
        PRESS_DB: begin
          if (frame_res == FRAME_KEY) begin
            if (key_new == cand_q) begin
              cnt_d = cnt_inc;
              if (cnt_inc == DB_LAST) begin
                state_d     = HELD;
                cnt_d       = '0;
                key_valid_d = 1'b1;
                key_code_d  = cand_q;
              end
            end else begin
              cand_d = key_new;
              cnt_d  = CW'(1);
            end
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (frame_res == FRAME_NONE) begin
            if (DEBOUNCE <= 1) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = REL_DB;
              cnt_d   = CW'(1);
            end
          end
        end
        REL_DB: begin
          if (frame_res == FRAME_NONE) begin
            cnt_d = cnt_inc;
            if (cnt_inc == DB_LAST) begin
              state_d = IDLE;
              cnt_d   = '0;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
      endcase
    end
  end

  assign keypadr   = row_q;
  assign key_valid = key_valid_q;
  assign key_code  = key_code_q;

endmodule

// File: rtl/keypad_entry.sv
// Keypad front end for the countdown clock: scans and debounces the matrix,
// shifts accepted digits into a two-digit BCD minute buffer, clears it on '*'
// and issues a one-cycle load strobe on '#'.
module keypad_entry
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 4000,
  parameter int DEBOUNCE = 8
) (
  input logic            clk,
  input logic            rst_n,
  keypad_entry_if.master bus
);

  logic [3:0] scan_row;
  logic       scan_key_valid;
  logic [3:0] scan_key_code;

  logic [7:0] minute_q, minute_d;
  logic       load_q, load_d;

  keypad_scan #(
    .SCAN_DIV (SCAN_DIV),
    .DEBOUNCE (DEBOUNCE)
  ) u_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .keypadc   (bus.keypadc),
    .keypadr   (scan_row),
    .key_valid (scan_key_valid),
    .key_code  (scan_key_code)
  );

  // Entry buffer and load strobe registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      minute_q <= 8'h00;
      load_q   <= 1'b0;
    end else begin
      minute_q <= minute_d;
      load_q   <= load_d;
    end
  end

  // Act on each accepted key: digits shift in (old tens drop out), '*' clears, '#' loads.
  always_comb begin
    minute_d = minute_q;
    load_d   = 1'b0;
    if (scan_key_valid) begin
      if (scan_key_code <= 4'd9) begin
        minute_d = {minute_q[3:0], scan_key_code};
      end else if (scan_key_code == KEY_STAR) begin
        minute_d = 8'h00;
      end else if (scan_key_code == KEY_HASH) begin
        load_d = 1'b1;
      end
    end
  end

  assign bus.keypadr   = scan_row;
  assign bus.key_valid = scan_key_valid;
  assign bus.key_code  = scan_key_code;
  assign bus.minute    = minute_q;
  assign bus.load      = load_q;

endmodule
